ysyx_25040129_imem_rsp: RTL and testbench

AXI4-Lite read-channel responder that serves instruction fetches from an internal word-addressed memory. It is the slave end of the fetch unit's AR/R handshake: it accepts one address, waits a configurable (optionally randomized) latency, then returns one word with a response code. A side-band load port lets the bench or boot logic preload the array.

---
 rtl/ysyx_25040129_imem_rsp_pkg.sv | 19 +
 rtl/ysyx_25040129_imem_rsp_if.sv | 22 ++
 rtl/ysyx_25040129_lfsr8.sv | 24 ++
 rtl/ysyx_25040129_imem_rsp.sv | 129 ++++++++++++
 tb/tb_ysyx_25040129_imem_rsp.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25040129_imem_rsp_pkg.sv
// rtl/ysyx_25040129_imem_rsp_pkg.sv - shared constants and types for the instruction memory responder
package ysyx_25040129_imem_rsp_pkg;

    localparam logic [31:0] FLASH_START = 32'h3000_0000;
    localparam logic [7:0]  LFSR_SEED   = 8'hA5;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } rresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_25040129_imem_rsp_if.sv
// rtl/ysyx_25040129_imem_rsp_if.sv - AXI4-Lite read address/data channel bundle
interface ysyx_25040129_imem_rsp_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_25040129_lfsr8.sv
// rtl/ysyx_25040129_lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module ysyx_25040129_lfsr8
    import ysyx_25040129_imem_rsp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign state_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ysyx_25040129_imem_rsp.sv
// rtl/ysyx_25040129_imem_rsp.sv - AXI4-Lite read responder serving fetches from a preloadable word array
module ysyx_25040129_imem_rsp
    import ysyx_25040129_imem_rsp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = FLASH_START,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter int          RAND_EN     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_25040129_imem_rsp_if.slave      bus,
    input  logic                         init_we,
    input  logic [31:0]                  init_addr,
    input  logic [31:0]                  init_data
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [7:0]  lfsr;
    logic        lfsr_unused;
    logic [4:0]  delay;
    logic        enter_resp;
    logic [31:0] rd_addr, rd_off, init_off;
    logic        init_ok;

    ysyx_25040129_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    assign lfsr_unused = ^lfsr[7:3];
    assign delay = 5'(LATENCY) + ((RAND_EN != 0) ? {2'b00, lfsr[2:0]} : 5'd0);

    // A zero-delay read samples the array on the handshake edge itself, before araddr is latched.
    assign rd_addr  = (state_q == ST_IDLE) ? bus.araddr : addr_q;
    assign rd_off   = rd_addr - BASE_ADDR;
    assign init_off = init_addr - BASE_ADDR;
    assign init_ok  = (init_addr[1:0] == 2'b00) && (init_off < SPAN);

    assign bus.arready = rst && (state_q == ST_IDLE);
    assign bus.rvalid  = (state_q == ST_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arvalid) begin
                    addr_d = bus.araddr;
                    cnt_d  = delay;
                    if (delay == 5'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 5'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                if (bus.rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            if (rd_addr[1:0] != 2'b00) begin
                rresp_d = RESP_SLVERR;
                rdata_d = 32'h0;
            end else if (rd_off >= SPAN) begin
                rresp_d = RESP_DECERR;
                rdata_d = 32'h0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem_q[rd_off[AW+1:2]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            rresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // Preload path is independent of reset and FSM state; contents survive reset.
    always_ff @(posedge clk) begin
        if (init_we && init_ok) begin
            mem_q[init_off[AW+1:2]] <= init_data;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_imem_rsp.sv
// tb/tb_ysyx_25040129_imem_rsp.sv - directed bench for the instruction memory responder
module tb_ysyx_25040129_imem_rsp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_we = 1'b0;
    logic [31:0] init_addr = 32'h0;
    logic [31:0] init_data = 32'h0;
    logic [7:0]  m_lfsr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ysyx_25040129_imem_rsp_if if0 ();
    ysyx_25040129_imem_rsp_if if1 ();
    ysyx_25040129_imem_rsp_if if2 ();

    ysyx_25040129_imem_rsp #(.LATENCY(1), .RAND_EN(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));
    ysyx_25040129_imem_rsp #(.LATENCY(0), .RAND_EN(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));
    ysyx_25040129_imem_rsp #(.LATENCY(2), .RAND_EN(1)) dut2 (
        .clk(clk), .rst(rst), .bus(if2),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

    // Reference LFSR built from the polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
    always @(posedge clk) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic test_reset;
        if0.arvalid = 0; if0.araddr = 0; if0.rready = 1;
        if1.arvalid = 0; if1.araddr = 0; if1.rready = 1;
        if2.arvalid = 0; if2.araddr = 0; if2.rready = 1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if0.arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b expected 0", if0.arready); end
        checks++; if (if0.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", if0.rvalid); end
        checks++; if (if0.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", if0.rdata); end
        checks++; if (if0.rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b expected 00", if0.rresp); end
        // preload while held in reset, including writes that must be dropped
        load_word(32'h3000_0000, 32'h0000_0413);
        load_word(32'h3000_0004, 32'h0010_0493);
        load_word(32'h3000_0008, 32'h0020_0513);
        load_word(32'h3000_0FFC, 32'hCAFE_F00D);
        load_word(32'h3000_0001, 32'hFFFF_FFFF);
        load_word(32'h2FFF_FFFC, 32'hFFFF_FFFF);
        load_word(32'h3000_1000, 32'hFFFF_FFFF);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (if0.arready !== 1'b1) begin errors++; $display("FAIL post_reset_arready: got %b expected 1", if0.arready); end
        checks++; if (if2.rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b expected 0", if2.rvalid); end
    endtask

    task automatic test_latency1;
        @(negedge clk);
        if0.arvalid = 1; if0.araddr = 32'h3000_0004; if0.rready = 1;
        @(negedge clk);
        if0.arvalid = 0;
        checks++; if (if0.rvalid !== 1'b0) begin errors++; $display("FAIL lat1_wait_rvalid: got %b expected 0", if0.rvalid); end
        checks++; if (if0.arready !== 1'b0) begin errors++; $display("FAIL lat1_wait_arready: got %b expected 0", if0.arready); end
        @(negedge clk);
        checks++; if (if0.rvalid !== 1'b1) begin errors++; $display("FAIL lat1_rvalid: got %b expected 1", if0.rvalid); end
        checks++; if (if0.rdata !== 32'h0010_0493) begin errors++; $display("FAIL lat1_rdata: got %h expected 00100493", if0.rdata); end
        checks++; if (if0.rresp !== 2'b00) begin errors++; $display("FAIL lat1_rresp: got %b expected 00", if0.rresp); end
        @(negedge clk);
        checks++; if (if0.rvalid !== 1'b0 || if0.arready !== 1'b1) begin errors++; $display("FAIL lat1_done: got rvalid=%b arready=%b expected 0/1", if0.rvalid, if0.arready); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        if1.arvalid = 1; if1.araddr = 32'h3000_0000; if1.rready = 1;
        @(negedge clk);
        if1.araddr = 32'h3000_0004;
        checks++; if (if1.rvalid !== 1'b1 || if1.arready !== 1'b0) begin errors++; $display("FAIL b2b_first_hs: got rvalid=%b arready=%b expected 1/0", if1.rvalid, if1.arready); end
        checks++; if (if1.rdata !== 32'h0000_0413) begin errors++; $display("FAIL b2b_first_data: got %h expected 00000413", if1.rdata); end
        @(negedge clk);
        checks++; if (if1.rvalid !== 1'b0 || if1.arready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got rvalid=%b arready=%b expected 0/1", if1.rvalid, if1.arready); end
        @(negedge clk);
        if1.arvalid = 0;
        checks++; if (if1.rvalid !== 1'b1 || if1.arready !== 1'b0) begin errors++; $display("FAIL b2b_second_hs: got rvalid=%b arready=%b expected 1/0", if1.rvalid, if1.arready); end
        checks++; if (if1.rdata !== 32'h0010_0493) begin errors++; $display("FAIL b2b_second_data: got %h expected 00100493", if1.rdata); end
        @(negedge clk);
        checks++; if (if1.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", if1.rvalid); end
    endtask

    task automatic test_decode;
        logic [31:0] addrs [4];
        logic [1:0]  resps [4];
        logic [31:0] datas [4];
        addrs = '{32'h3000_0002, 32'h3000_1000, 32'h2FFF_FFFC, 32'h3000_0FFC};
        resps = '{2'b10, 2'b11, 2'b11, 2'b00};
        datas = '{32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if1.arvalid = 1; if1.araddr = addrs[i]; if1.rready = 1;
            @(negedge clk);
            if1.arvalid = 0;
            checks++; if (if1.rvalid !== 1'b1 || if1.rresp !== resps[i]) begin errors++; $display("FAIL decode_resp[%0d]: got rvalid=%b rresp=%b expected 1/%b", i, if1.rvalid, if1.rresp, resps[i]); end
            checks++; if (if1.rdata !== datas[i]) begin errors++; $display("FAIL decode_data[%0d]: got %h expected %h", i, if1.rdata, datas[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        if0.arvalid = 1; if0.araddr = 32'h3000_0008; if0.rready = 0;
        @(negedge clk);
        if0.arvalid = 0;
        // rewrite lands on the same edge the read samples the array
        init_we = 1; init_addr = 32'h3000_0008; init_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (if0.rvalid !== 1'b1 || if0.rdata !== 32'h0020_0513) begin errors++; $display("FAIL hold[%0d]: got rvalid=%b rdata=%h expected 1/00200513", i, if0.rvalid, if0.rdata); end
        end
        init_we = 0; if0.rready = 1;
        @(negedge clk);
        checks++; if (if0.rvalid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", if0.rvalid); end
        if0.arvalid = 1; if0.araddr = 32'h3000_0008;
        @(negedge clk);
        if0.arvalid = 0;
        @(negedge clk);
        checks++; if (if0.rvalid !== 1'b1 || if0.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_newdata: got rvalid=%b rdata=%h expected 1/deadbeef", if0.rvalid, if0.rdata); end
        @(negedge clk);
    endtask

    task automatic test_random_delay;
        int exp_d;
        int k;
        for (int r = 0; r < 64; r++) begin
            @(negedge clk);
            if2.arvalid = 1; if2.araddr = 32'h3000_0000; if2.rready = 1;
            exp_d = 2 + int'(m_lfsr[2:0]);
            k = 0;
            @(negedge clk);
            if2.arvalid = 0;
            while (if2.rvalid !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            checks++; if (k !== exp_d) begin errors++; $display("FAIL rand_delay[%0d]: got %0d expected %0d", r, k, exp_d); end
            checks++; if (k < 2 || k > 9) begin errors++; $display("FAIL rand_range[%0d]: got %0d expected 2..9", r, k); end
        end
        checks++; if (if2.rdata !== 32'h0000_0413) begin errors++; $display("FAIL rand_data: got %h expected 00000413", if2.rdata); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        if2.arvalid = 1; if2.araddr = 32'h3000_0000; if2.rready = 1;
        @(negedge clk);
        if2.arvalid = 0;
        rst = 0;
        @(negedge clk);
        checks++; if (if2.rvalid !== 1'b0 || if2.arready !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got rvalid=%b arready=%b expected 0/0", if2.rvalid, if2.arready); end
        rst = 1;
        repeat (12) begin
            @(negedge clk);
            checks++; if (if2.rvalid !== 1'b0 || if2.arready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got rvalid=%b arready=%b expected 0/1", if2.rvalid, if2.arready); end
        end
        if0.arvalid = 1; if0.araddr = 32'h3000_0000; if0.rready = 1;
        @(negedge clk);
        if0.arvalid = 0;
        @(negedge clk);
        checks++; if (if0.rvalid !== 1'b1 || if0.rdata !== 32'h0000_0413 || if0.rresp !== 2'b00) begin errors++; $display("FAIL midrst_fresh: got rvalid=%b rdata=%h rresp=%b expected 1/00000413/00", if0.rvalid, if0.rdata, if0.rresp); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_latency1;
        test_back_to_back;
        test_decode;
        test_hold;
        test_random_delay;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
